// File: rtl/addsub_serial.sv
// ---------------------------------------------------------------------------
// addsub_serial
//   Digit-serial two's-complement adder/subtractor. Operands are captured on
//   an in_valid/in_ready handshake, then processed DIGIT bits per clock, LSB
//   first. After WIDTH/DIGIT cycles the result, carry-out and signed overflow
//   are presented on an out_valid/out_ready handshake. Only one operation is
//   in flight at a time.
//
// Parameters
//   WIDTH  operand/result width (>= 2)
//   DIGIT  bits processed per clock (WIDTH must be a multiple of DIGIT)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (aborts any operation)
//   in_valid   operands valid           in_ready   unit idle, can accept
//   op         0 = a+b, 1 = a-b         a, b       signed operands
//   out_valid  result valid             out_ready  consumer accepts result
//   sum        signed result            c_out      carry out of MSB
//   ovf        signed overflow (carry into MSB ^ carry out of MSB)
//
// Build option
//   ADDSUB_SAT_EN  when defined, an overflowing result is clamped to the most
//                  positive / most negative value; c_out and ovf stay raw.
// ---------------------------------------------------------------------------
module addsub_serial #(
  parameter int WIDTH = 4,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
      $error("addsub_serial: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  // Datapath for one digit
  logic [DIGIT:0]   digit_sum;
  logic             carry_into_msb;
  logic             raw_ovf;
  logic [WIDTH-1:0] res_shift;
  logic [WIDTH-1:0] result_final;

  assign digit_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry_q};

  // The carry entering the top bit of the digit is recovered from the sum bit:
  // s = a ^ b ^ cin  =>  cin = s ^ a ^ b. Only meaningful in the last digit,
  // where the top bit of the digit is the operand MSB.
  assign carry_into_msb = digit_sum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
  assign raw_ovf        = carry_into_msb ^ digit_sum[DIGIT];

  // New digit enters the result register from the top; after N cycles the
  // first digit has travelled down to the LSB position.
  assign res_shift = (res_q >> DIGIT)
                   | (WIDTH'(digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));

`ifdef ADDSUB_SAT_EN
  always_comb begin
    result_final = res_shift;
    if (raw_ovf) begin
      // Wrapped MSB of 1 means two positives overflowed, and vice versa.
      result_final = res_shift[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                        : {1'b1, {(WIDTH-1){1'b0}}};
    end
  end
`else
  assign result_final = res_shift;
`endif

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + 1: invert b here, carry-in supplies the +1.
          a_d     = a;
          b_d     = b ^ {WIDTH{op}};
          carry_d = op;
          res_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        res_d   = res_shift;
        carry_d = digit_sum[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          cnt_d   = '0;
          sum_d   = result_final;
          c_out_d = digit_sum[DIGIT];
          ovf_d   = raw_ovf;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

endmodule
